// File: rtl/result_window_sink_pkg.sv
// rtl/result_window_sink_pkg.sv - shared types, defaults and sizing helper for the result window sink
package result_sink_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } sink_state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_WINDOW = 8;

  // Occupancy needs one extra bit so that "full" (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_window_sink_fifo.sv
// rtl/result_window_sink_fifo.sv - synchronous FIFO with occupancy count buffering incoming results
module result_fifo
  import result_sink_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Requests are qualified here so a push while full never overwrites an entry.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;

endmodule

// File: rtl/result_window_sink.sv
// rtl/result_window_sink.sv - buffers result samples and reports sum/max/zero-count per fixed window
module result_window_sink
  import result_sink_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WINDOW = DEF_WINDOW,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [WIDTH-1:0] rpt_sum,
  output logic [WIDTH-1:0] rpt_max,
  output logic [7:0]       rpt_zero_cnt,
  output logic [CW-1:0]    fifo_count
);

  sink_state_t r_state;
  sink_state_t w_state_nxt;

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_max;
  logic [7:0]       r_zero_cnt;
  logic [7:0]       r_smp_cnt;

  logic [WIDTH-1:0] r_rpt_sum;
  logic [WIDTH-1:0] r_rpt_max;
  logic [7:0]       r_rpt_zero_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_take;
  logic             w_last;
  logic [WIDTH-1:0] w_pop_data;
  logic [WIDTH-1:0] w_next_sum;
  logic [WIDTH-1:0] w_next_max;
  logic [7:0]       w_next_zero_cnt;

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (in_valid),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign in_ready = !w_full;

  assign w_last          = (({1'b0, r_smp_cnt} + 9'd1) == 9'(WINDOW));
  assign w_next_sum      = r_sum + w_pop_data;
  assign w_next_max      = ((r_smp_cnt == 8'd0) || (w_pop_data > r_max)) ? w_pop_data : r_max;
  assign w_next_zero_cnt = r_zero_cnt + ((w_pop_data == '0) ? 8'd1 : 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      ACCUM: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_last) begin
            w_state_nxt = REPORT;
          end
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          w_take      = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Report registers are separate from the running accumulators so they read 0 outside REPORT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum          <= '0;
      r_max          <= '0;
      r_zero_cnt     <= '0;
      r_smp_cnt      <= '0;
      r_rpt_sum      <= '0;
      r_rpt_max      <= '0;
      r_rpt_zero_cnt <= '0;
    end else if (w_take) begin
      r_sum          <= '0;
      r_max          <= '0;
      r_zero_cnt     <= '0;
      r_smp_cnt      <= '0;
      r_rpt_sum      <= '0;
      r_rpt_max      <= '0;
      r_rpt_zero_cnt <= '0;
    end else if (w_pop) begin
      r_sum      <= w_next_sum;
      r_max      <= w_next_max;
      r_zero_cnt <= w_next_zero_cnt;
      r_smp_cnt  <= r_smp_cnt + 8'd1;
      if (w_last) begin
        r_rpt_sum      <= w_next_sum;
        r_rpt_max      <= w_next_max;
        r_rpt_zero_cnt <= w_next_zero_cnt;
      end
    end
  end

  assign rpt_valid    = (r_state == REPORT);
  assign rpt_sum      = r_rpt_sum;
  assign rpt_max      = r_rpt_max;
  assign rpt_zero_cnt = r_rpt_zero_cnt;

endmodule

// File: doc/result_window_sink.md
Name: result_window_sink

Overview:
- Downstream consumer of the 32-bit per-cycle result stream produced by the array/transform stage.
- Buffers incoming results in a small FIFO and accumulates statistics over fixed-size windows.
- At the end of each window, presents one summary record under a valid/ready handshake.
- Gives the concolic bench a deep sequential target: FIFO occupancy, window counting and backpressure.

Parameters:
- WIDTH, 32, data width of input samples and of rpt_sum/rpt_max.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- WINDOW, 8, samples per report; range 1..255.

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on posedge clk only.
- in_valid  input  1  in_data is presented this cycle.
- in_data  input  WIDTH  result sample.
- in_ready  output  1  FIFO can accept a sample; equals !full.
- rpt_ready  input  1  consumer accepts the report.
- rpt_valid  output  1  summary record valid.
- rpt_sum  output  WIDTH  sum of window samples, modulo 2^WIDTH.
- rpt_max  output  WIDTH  unsigned maximum of window samples.
- rpt_zero_cnt  output  8  number of zero-valued samples in the window.
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Taken when reset=1 at posedge clk, regardless of the current state.
  - FIFO is emptied (count 0, pointers 0) and the FSM goes to ACCUM.
  - Accumulators and the sample counter clear to 0.
  - After reset: rpt_valid=0, rpt_sum=0, rpt_max=0, rpt_zero_cnt=0, fifo_count=0, in_ready=1.
  - A window in progress is discarded; no partial report is produced.
- Push: occurs when in_valid && in_ready. in_ready is combinational from count and depends only on full, not on the current pop.
- Pop: occurs only in ACCUM when the FIFO is not empty; at most one pop per cycle.
- Latency: a sample pushed at edge t is popped no earlier than edge t+1.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
- FSM states: ACCUM and REPORT.
- ACCUM, on each pop of sample d:
  - sum <= sum + d, truncated to WIDTH.
  - max <= (d > max) ? d : max, unsigned compare; the first sample of a window loads max directly.
  - zero_cnt increments if d == 0.
  - smp_cnt increments.
  - When the pop makes smp_cnt == WINDOW, the FSM moves to REPORT on the same edge, with the final accumulator values latched.
- REPORT:
  - rpt_valid=1 and rpt_* hold stable; no pops occur.
  - Pushes continue until the FIFO is full.
  - On rpt_valid && rpt_ready: accumulators and smp_cnt clear and the FSM returns to ACCUM.
  - rpt_valid falls on that same edge; the next pop happens no earlier than the following cycle.
- rpt_* outputs are registered and drive 0 whenever rpt_valid=0.
- A FIFO that stays empty in ACCUM is a stall: no state changes except pushes.
- in_valid while full: the sample is dropped by the producer's protocol (the producer must hold it); the sink must not overwrite any entry.
- X on in_data while in_valid=0 has no effect.

Decomposition:
- Package result_sink_pkg holds:
  - enum sink_state_t {ACCUM, REPORT}.
  - localparam for the default WIDTH/DEPTH/WINDOW.
  - A function computing the count width from DEPTH.
- Sub-module result_fifo: synchronous FIFO with count, full/empty, push/pop, and the same clk/reset.
- The FSM and accumulators live in the top module.

Test Plan:
- After reset, push 1,2,...,8 back-to-back with rpt_ready=1 -> one report: rpt_sum=36, rpt_max=8, rpt_zero_cnt=0; rpt_valid high for exactly 1 cycle.
- Push 0,0,5,0,0xFFFFFFFF,3,0,1 -> rpt_sum=0x00000008 (wraps), rpt_max=0xFFFFFFFF, rpt_zero_cnt=4.
- Hold rpt_ready=0 after the first window completes, then push 6 more samples -> in_ready falls after 4 accepted, fifo_count=4, rpt_* stable. Raising rpt_ready -> the next window consumes the buffered samples in order.
- Simultaneous push/pop while the FIFO holds 2 -> fifo_count stays 2 and the data order is preserved across pointer wrap.
- Assert reset for 1 cycle after 5 pops of a window -> all outputs 0 and fifo_count=0. The next 8 pushes of 10 -> rpt_sum=80, rpt_max=10.
- With WINDOW=1, push 7 then 0 -> two reports: (7,7,0) then (0,0,1).
